dmem_arbiter: RTL and testbench

//   Shares the single-port data memory of the memory stage between the core
//   (MEM-stage load/store) and a secondary word-wide master (DMA/debug).
//   One grant per cycle, core has priority; a starvation counter guarantees
//   DMA progress by forcing a DMA grant and a one-cycle core stall.

---
 rtl/dmem_arbiter.sv | 121 ++++++++++++
 tb/tb_dmem_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the MEM-stage core port and a
// word-wide DMA/debug master. The core has priority, and starvation forces periodic DMA grants.
module dmem_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_req_i,
  input  logic                  core_we_i,
  input  logic [2:0]            core_funct3_i,
  input  logic [DATA_WIDTH-1:0] core_addr_i,
  input  logic [DATA_WIDTH-1:0] core_wdata_i,
  output logic                  core_stall_o,
  output logic                  core_rvalid_o,
  output logic [DATA_WIDTH-1:0] core_rdata_o,
  input  logic                  dma_req_i,
  input  logic                  dma_we_i,
  input  logic [DATA_WIDTH-1:0] dma_addr_i,
  input  logic [DATA_WIDTH-1:0] dma_wdata_i,
  output logic                  dma_gnt_o,
  output logic                  dma_rvalid_o,
  output logic [DATA_WIDTH-1:0] dma_rdata_o,
  output logic                  mem_we_o,
  output logic                  mem_re_o,
  output logic [2:0]            mem_funct3_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
  localparam logic [2:0] FUNCT3_WORD = 3'b010;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  logic [CNT_W-1:0]      starve_cnt;
  owner_t                rd_owner_p1;
  owner_t                rd_owner_nxt;
  logic                  force_dma;
  logic                  core_gnt;
  logic                  dma_gnt;
  logic [DATA_WIDTH-1:0] core_rdata_q;
  logic [DATA_WIDTH-1:0] dma_rdata_q;
  logic                  unused_dma_addr_lsbs;

  assign unused_dma_addr_lsbs = ^dma_addr_i[1:0];

  // Stage p0: grant decision and memory port drive, all in the issue cycle
  always_comb begin
    force_dma = dma_req_i & (starve_cnt == LIMIT_C);
    core_gnt  = ~rst & core_req_i & ~force_dma;
    dma_gnt   = ~rst & dma_req_i & ~core_gnt;
  end

  assign core_stall_o = core_req_i & ~core_gnt;
  assign dma_gnt_o    = dma_gnt;

  always_comb begin
    mem_we_o     = 1'b0;
    mem_re_o     = 1'b0;
    mem_funct3_o = 3'b000;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    if (core_gnt) begin
      mem_we_o     = core_we_i;
      mem_re_o     = ~core_we_i;
      mem_funct3_o = core_funct3_i;
      mem_addr_o   = core_addr_i;
      mem_wdata_o  = core_wdata_i;
    end else if (dma_gnt) begin
      mem_we_o     = dma_we_i;
      mem_re_o     = ~dma_we_i;
      mem_funct3_o = FUNCT3_WORD;
      mem_addr_o   = {dma_addr_i[DATA_WIDTH-1:2], 2'b00};
      mem_wdata_o  = dma_wdata_i;
    end
  end

  always_comb begin
    rd_owner_nxt = OWN_NONE;
    if (core_gnt && !core_we_i)
      rd_owner_nxt = OWN_CORE;
    else if (dma_gnt && !dma_we_i)
      rd_owner_nxt = OWN_DMA;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt   <= '0;
      rd_owner_p1  <= OWN_NONE;
      core_rdata_q <= '0;
      dma_rdata_q  <= '0;
    end else begin
      if (dma_req_i && !dma_gnt) begin
        if (starve_cnt != LIMIT_C)
          starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end
      rd_owner_p1 <= rd_owner_nxt;
      if (rd_owner_p1 == OWN_CORE)
        core_rdata_q <= mem_rdata_i;
      if (rd_owner_p1 == OWN_DMA)
        dma_rdata_q <= mem_rdata_i;
    end
  end

  // Stage p1: memory returns read data; route it to the tagged owner.
  // Reset masks the valid so a read pending across reset is dropped.
  assign core_rvalid_o = (rd_owner_p1 == OWN_CORE) & ~rst;
  assign dma_rvalid_o  = (rd_owner_p1 == OWN_DMA) & ~rst;
  assign core_rdata_o  = core_rvalid_o ? mem_rdata_i : core_rdata_q;
  assign dma_rdata_o   = dma_rvalid_o ? mem_rdata_i : dma_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small word-addressed memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req_i, core_we_i;
  logic [2:0]  core_funct3_i;
  logic [31:0] core_addr_i, core_wdata_i;
  logic        core_stall_o, core_rvalid_o;
  logic [31:0] core_rdata_o;
  logic        dma_req_i, dma_we_i;
  logic [31:0] dma_addr_i, dma_wdata_i;
  logic        dma_gnt_o, dma_rvalid_o;
  logic [31:0] dma_rdata_o;
  logic        mem_we_o, mem_re_o;
  logic [2:0]  mem_funct3_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata_i;

  logic [31:0] mem [0:63];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_funct3_i(core_funct3_i),
    .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
    .core_stall_o(core_stall_o), .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
    .dma_req_i(dma_req_i), .dma_we_i(dma_we_i), .dma_addr_i(dma_addr_i),
    .dma_wdata_i(dma_wdata_i), .dma_gnt_o(dma_gnt_o), .dma_rvalid_o(dma_rvalid_o),
    .dma_rdata_o(dma_rdata_o), .mem_we_o(mem_we_o), .mem_re_o(mem_re_o),
    .mem_funct3_o(mem_funct3_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
  );

  // Memory model: contents C0DE0000+index, word 4 = DEADBEEF, reloaded on reset
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hC0DE0000 + i;
      mem[4] <= 32'hDEADBEEF;
      mem_rdata_i <= 32'h0;
    end else begin
      if (mem_we_o) mem[mem_addr_o[7:2]] <= mem_wdata_o;
      if (mem_re_o) mem_rdata_i <= mem[mem_addr_o[7:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_req_i = 0; core_we_i = 0; core_funct3_i = 3'b000;
    core_addr_i = 0; core_wdata_i = 0;
    dma_req_i = 0; dma_we_i = 0; dma_addr_i = 0; dma_wdata_i = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    cyc();
    cyc();
    // Reset state: requests present but no grants
    core_req_i = 1; dma_req_i = 1;
    #2;
    check("rst_dma_gnt", 32'(dma_gnt_o), 32'd0);
    check("rst_mem_re", 32'(mem_re_o), 32'd0);
    check("rst_core_rvalid", 32'(core_rvalid_o), 32'd0);
    check("rst_dma_rvalid", 32'(dma_rvalid_o), 32'd0);
    check("rst_core_rdata", core_rdata_o, 32'h0);
    check("rst_dma_rdata", dma_rdata_o, 32'h0);
    check("rst_starve", 32'(dut.starve_cnt), 32'd0);
    idle_inputs();
    cyc();
    rst = 1'b0;

    // 1: core load from 0x10
    cyc();
    core_req_i = 1; core_funct3_i = 3'b010; core_addr_i = 32'h10;
    #2;
    check("t1_mem_re", 32'(mem_re_o), 32'd1);
    check("t1_mem_addr", mem_addr_o, 32'h10);
    check("t1_funct3", 32'(mem_funct3_o), 32'd2);
    check("t1_stall", 32'(core_stall_o), 32'd0);
    cyc();
    idle_inputs();
    #2;
    check("t1_rvalid", 32'(core_rvalid_o), 32'd1);
    check("t1_rdata", core_rdata_o, 32'hDEADBEEF);
    check("t1_dma_rvalid", 32'(dma_rvalid_o), 32'd0);
    cyc();
    #2;
    check("t1_rvalid_off", 32'(core_rvalid_o), 32'd0);
    check("t1_rdata_hold", core_rdata_o, 32'hDEADBEEF);
    check("idle_mem_re", 32'(mem_re_o), 32'd0);
    check("idle_mem_addr", mem_addr_o, 32'h0);

    // 2: DMA word write to 0x23
    cyc();
    dma_req_i = 1; dma_we_i = 1; dma_addr_i = 32'h23; dma_wdata_i = 32'hA5A5A5A5;
    #2;
    check("t2_gnt", 32'(dma_gnt_o), 32'd1);
    check("t2_mem_we", 32'(mem_we_o), 32'd1);
    check("t2_mem_re", 32'(mem_re_o), 32'd0);
    check("t2_mem_addr", mem_addr_o, 32'h20);
    check("t2_funct3", 32'(mem_funct3_o), 32'd2);
    check("t2_wdata", mem_wdata_o, 32'hA5A5A5A5);
    cyc();
    idle_inputs();
    #2;
    check("t2_no_rvalid", 32'(dma_rvalid_o), 32'd0);

    // 3: both requesting continuously, DMA forced every fifth cycle
    for (int i = 0; i < 10; i++) begin
      cyc();
      core_req_i = 1; core_we_i = 0; core_funct3_i = 3'b010; core_addr_i = 32'h0;
      dma_req_i = 1; dma_we_i = 0; dma_addr_i = 32'h30;
      #2;
      check($sformatf("t3_gnt_%0d", i), 32'(dma_gnt_o), (i % 5 == 4) ? 32'd1 : 32'd0);
      check($sformatf("t3_stall_%0d", i), 32'(core_stall_o), (i % 5 == 4) ? 32'd1 : 32'd0);
    end
    cyc();
    idle_inputs();
    cyc();

    // 4: core load 0x04 then DMA read 0x08, no cross-talk
    core_req_i = 1; core_funct3_i = 3'b010; core_addr_i = 32'h04;
    cyc();
    idle_inputs();
    dma_req_i = 1; dma_addr_i = 32'h08;
    #2;
    check("t4_core_rvalid", 32'(core_rvalid_o), 32'd1);
    check("t4_core_rdata", core_rdata_o, 32'hC0DE0001);
    check("t4_dma_rvalid0", 32'(dma_rvalid_o), 32'd0);
    cyc();
    idle_inputs();
    core_req_i = 1; core_funct3_i = 3'b010; core_addr_i = 32'h20;
    #2;
    check("t4_dma_rvalid", 32'(dma_rvalid_o), 32'd1);
    check("t4_dma_rdata", dma_rdata_o, 32'hC0DE0002);
    check("t4_core_rvalid0", 32'(core_rvalid_o), 32'd0);
    check("t4_core_hold", core_rdata_o, 32'hC0DE0001);
    cyc();
    idle_inputs();
    #2;
    check("t4_readback", core_rdata_o, 32'hA5A5A5A5);
    check("t4_dma_hold", dma_rdata_o, 32'hC0DE0002);

    // 5: reset right after a granted core load, with DMA partially starved
    cyc();
    core_req_i = 1; core_funct3_i = 3'b010; core_addr_i = 32'h04;
    dma_req_i = 1; dma_we_i = 1; dma_addr_i = 32'h3C;
    cyc();
    cyc();
    #2;
    check("t5_starve2", 32'(dut.starve_cnt), 32'd2);
    check("t5_core_gnt", 32'(mem_re_o), 32'd1);
    cyc();
    rst = 1'b1;
    #2;
    check("t5_rvalid_drop", 32'(core_rvalid_o), 32'd0);
    check("t5_dma_gnt", 32'(dma_gnt_o), 32'd0);
    check("t5_mem_re", 32'(mem_re_o), 32'd0);
    check("t5_mem_we", 32'(mem_we_o), 32'd0);
    cyc();
    #2;
    check("t5_starve0", 32'(dut.starve_cnt), 32'd0);
    check("t5_rvalid_after", 32'(core_rvalid_o), 32'd0);
    check("t5_core_rdata0", core_rdata_o, 32'h0);
    check("t5_dma_rdata0", dma_rdata_o, 32'h0);
    idle_inputs();
    cyc();
    rst = 1'b0;

    // 6: DMA alone, back-to-back reads every cycle
    for (int i = 0; i < 10; i++) begin
      cyc();
      dma_req_i = 1; dma_we_i = 0; dma_addr_i = 32'h40 + 32'(4 * i);
      #2;
      check($sformatf("t6_gnt_%0d", i), 32'(dma_gnt_o), 32'd1);
      check($sformatf("t6_starve_%0d", i), 32'(dut.starve_cnt), 32'd0);
      if (i > 0) begin
        check($sformatf("t6_rvalid_%0d", i), 32'(dma_rvalid_o), 32'd1);
        check($sformatf("t6_rdata_%0d", i), dma_rdata_o, 32'hC0DE0010 + 32'(i - 1));
        check($sformatf("t6_core_rvalid_%0d", i), 32'(core_rvalid_o), 32'd0);
      end
    end
    cyc();
    idle_inputs();
    #2;
    check("t6_last_rvalid", 32'(dma_rvalid_o), 32'd1);
    check("t6_last_rdata", dma_rdata_o, 32'hC0DE0019);
    cyc();
    #2;
    check("t6_rvalid_off", 32'(dma_rvalid_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
